// File: rtl/tile_reset_sequencer.sv
// TL-UL client that pulses one tile's reset register: assert, hold, deassert, read back.
// All host- and bus-facing control outputs are registered from the next-state decode.
module tile_reset_sequencer #(
    parameter int          NUM_TILES   = 4,
    parameter logic [20:0] BASE_ADDR   = 21'h0,
    parameter int          STRIDE      = 4,
    parameter int          HOLD_CYCLES = 16,
    parameter logic [11:0] SOURCE_ID   = 12'h0,
    localparam int         TILE_W      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TILE_W-1:0] req_tile,
    output logic              busy,
    output logic              done_valid,
    output logic              done_error,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [2:0]        a_opcode,
    output logic [2:0]        a_param,
    output logic [1:0]        a_size,
    output logic [11:0]       a_source,
    output logic [20:0]       a_address,
    output logic [7:0]        a_mask,
    output logic [63:0]       a_data,
    output logic              a_corrupt,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [2:0]        d_opcode,
    input  logic [11:0]       d_source,
    input  logic [63:0]       d_data
);
    localparam int OFF_W  = TILE_W + $clog2(STRIDE) + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [TILE_W:0] TILE_LIMIT = (TILE_W + 1)'(NUM_TILES);

    typedef enum logic [3:0] {
        IDLE, AS_A, AS_D, HOLD, DE_A, DE_D, RB_A, RB_D, DONE
    } state_t;

    state_t              state_r, state_s;
    logic [TILE_W-1:0]   tile_r, tile_s;
    logic [HOLD_W-1:0]   hold_r, hold_s;
    logic                err_s;
    logic                ack_ok_s, ackdata_ok_s, rb_bad_s;
    logic [20:0]         addr_s;

    function automatic logic [20:0] tile_addr(input logic [TILE_W-1:0] t);
        logic [OFF_W-1:0] off;
        off = OFF_W'(t) * OFF_W'(STRIDE);
        return BASE_ADDR + 21'(off);
    endfunction

    assign a_param   = 3'd0;
    assign a_size    = 2'd2;
    assign a_source  = SOURCE_ID;
    assign a_corrupt = 1'b0;

    // Response decode; the readback lane follows the latched address word
    always_comb begin
        ack_ok_s     = (d_opcode == 3'd0) && (d_source == SOURCE_ID);
        ackdata_ok_s = (d_opcode == 3'd1) && (d_source == SOURCE_ID);
        rb_bad_s     = d_data[a_address[2] ? 6'd32 : 6'd0];
        addr_s       = tile_addr(tile_s);
    end

    // Next-state, hold counter and error decision
    always_comb begin
        state_s = state_r;
        tile_s  = tile_r;
        hold_s  = hold_r;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    tile_s = req_tile;
                    if ({1'b0, req_tile} >= TILE_LIMIT) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = AS_A;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            AS_A: begin
                if (a_ready) state_s = AS_D;
                else         state_s = AS_A;
            end
            AS_D: begin
                if (d_valid) begin
                    if (!ack_ok_s) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else if (HOLD_CYCLES == 0) begin
                        state_s = DE_A;
                    end else begin
                        state_s = HOLD;
                        hold_s  = HOLD_W'(HOLD_CYCLES);
                    end
                end else begin
                    state_s = AS_D;
                end
            end
            HOLD: begin
                hold_s = hold_r - HOLD_W'(1);
                if (hold_r <= HOLD_W'(1)) state_s = DE_A;
                else                      state_s = HOLD;
            end
            DE_A: begin
                if (a_ready) state_s = DE_D;
                else         state_s = DE_A;
            end
            DE_D: begin
                if (d_valid) begin
                    if (!ack_ok_s) begin
                        state_s = DONE;
                        err_s   = 1'b1;
                    end else begin
                        state_s = RB_A;
                    end
                end else begin
                    state_s = DE_D;
                end
            end
            RB_A: begin
                if (a_ready) state_s = RB_D;
                else         state_s = RB_A;
            end
            RB_D: begin
                if (d_valid) begin
                    state_s = DONE;
                    err_s   = !ackdata_ok_s || rb_bad_s;
                end else begin
                    state_s = RB_D;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, latched tile, hold counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            tile_r     <= '0;
            hold_r     <= '0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            done_valid <= 1'b0;
            done_error <= 1'b0;
            a_valid    <= 1'b0;
            d_ready    <= 1'b0;
            a_opcode   <= 3'd0;
            a_address  <= tile_addr('0);
            a_mask     <= tile_addr('0) & 21'h4 ? 8'hF0 : 8'h0F;
            a_data     <= 64'd0;
        end else begin
            state_r    <= state_s;
            tile_r     <= tile_s;
            hold_r     <= hold_s;
            req_ready  <= (state_s == IDLE);
            busy       <= (state_s != IDLE);
            done_valid <= (state_s == DONE);
            done_error <= err_s;
            a_valid    <= (state_s == AS_A) || (state_s == DE_A) || (state_s == RB_A);
            d_ready    <= (state_s == AS_D) || (state_s == DE_D) || (state_s == RB_D);
            a_opcode   <= (state_s == RB_A) ? 3'd4 : 3'd0;
            a_address  <= addr_s;
            a_mask     <= addr_s[2] ? 8'hF0 : 8'h0F;
            a_data     <= (state_s == AS_A) ? {2{32'd1}} : 64'd0;
        end
    end
endmodule
